// File: rtl/vram_pkg.sv
// Shared types for the framebuffer port arbiter: FSM states and the latched
// request record.
package vram_pkg;

  localparam int VRAM_ADDR_W = 24;
  localparam int VRAM_DATA_W = 16;
  localparam int VRAM_MASK_W = 4;

  typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} arb_state_t;

  // Field widths track the package constants; the arbiter's width parameters default to them.
  typedef struct packed {
    logic                   wr;
    logic [VRAM_MASK_W-1:0] mask;
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] data;
  } vram_req_t;

endpackage

// File: rtl/vram_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_picker #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  int j;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(ptr_i) + i) % N;
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Round-robin owner of the single framebuffer port; one transaction in flight,
// requester fields latched at grant, watchdog converts a missing ack into a flagged ack.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = VRAM_ADDR_W,
  parameter int DATA_W  = VRAM_DATA_W,
  parameter int MASK_W  = VRAM_MASK_W,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      reset_ni,
  input  logic [NUM_REQ-1:0]        req_sel_i,
  input  logic [NUM_REQ-1:0]        req_wr_i,
  input  logic [NUM_REQ*MASK_W-1:0] req_mask_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ack_o,
  output logic [DATA_W-1:0]         req_data_o,
  output logic                      vram_sel_o,
  output logic                      vram_wr_o,
  output logic [MASK_W-1:0]         vram_mask_o,
  output logic [ADDR_W-1:0]         vram_addr_o,
  output logic [DATA_W-1:0]         vram_data_o,
  input  logic                      vram_ack_i,
  input  logic [DATA_W-1:0]         vram_data_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o,
  output logic                      timeout_o
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t         state_q, state_d;
  vram_req_t          lat_q, lat_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               sel_q, sel_d;
  logic               to_q, to_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_vld;
  logic [PTR_W-1:0]   pick_idx;
  logic               wd_exp;

  rr_picker #(.N(NUM_REQ), .IW(PTR_W)) u_pick (
    .req_i   (req_sel_i),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  assign wd_exp = (TIMEOUT != 0) && (wd_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    wd_d    = wd_q;
    grant_d = grant_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    sel_d   = sel_q;
    to_d    = to_q;
    unique case (state_q)
      IDLE: if (pick_vld) begin
        lat_d.wr   = req_wr_i[pick_idx];
        lat_d.mask = req_mask_i[int'(pick_idx)*MASK_W +: MASK_W];
        lat_d.addr = req_addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
        lat_d.data = req_data_i[int'(pick_idx)*DATA_W +: DATA_W];
        grant_d    = pick_gnt;
        gidx_d     = pick_idx;
        sel_d      = 1'b1;
        wd_d       = '0;
        state_d    = ACTIVE;
      end
      ACTIVE: begin
        // A real ack beats a simultaneous watchdog expiry.
        if (vram_ack_i || wd_exp) begin
          sel_d   = 1'b0;
          ack_d   = grant_q;
          rdata_d = vram_ack_i ? vram_data_i : '0;
          to_d    = to_q | ~vram_ack_i;
          ptr_d   = gidx_q;
          state_d = RELEASE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RELEASE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      lat_q   <= '0;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      gidx_q  <= '0;
      wd_q    <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      sel_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      wd_q    <= wd_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      sel_q   <= sel_d;
      to_q    <= to_d;
    end
  end

  assign req_ack_o   = ack_q;
  assign req_data_o  = rdata_q;
  assign vram_sel_o  = sel_q;
  assign vram_wr_o   = lat_q.wr;
  assign vram_mask_o = lat_q.mask;
  assign vram_addr_o = lat_q.addr;
  assign vram_data_o = lat_q.data;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != IDLE);
  assign timeout_o   = to_q;

endmodule
